// File: rtl/i2c_init_seq_if.sv
// i2c_init_seq_if: register-table read port between the
// init sequencer (master) and the table ROM (slave).
interface i2c_init_seq_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] oROM_ADDR;
  logic [15:0]       iROM_DATA;

  modport master (
    output oROM_ADDR,
    input  iROM_DATA
  );

  modport slave (
    input  oROM_ADDR,
    output iROM_DATA
  );
endinterface

// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a {sub,data} table and writes each word
// to one I2C slave as a 3-byte write, retrying on NACK.
module i2c_init_seq #(
  parameter int         CLK_FREQ   = 50000000,
  parameter int         I2C_FREQ   = 20000,
  parameter int         DEPTH      = 11,
  parameter int         ADDR_W     = 4,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  i2c_init_seq_if.master    rom,
  output logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic [ADDR_W-1:0] oERR_INDEX
);
  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW = $clog2(QDIV);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [3:0] MAXR = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, FETCH, START, BIT, STOP, GAP, DONE
  } state_t;

  state_t      state;
  logic [QW-1:0] qCnt;
  logic        qtick;
  logic [1:0]  qIdx;
  logic [1:0]  fCnt;
  logic [3:0]  bitCnt;
  logic [1:0]  byteCnt;
  logic [3:0]  retry;
  logic [23:0] frame;
  logic [23:0] txSh;
  logic        nack;
  logic        autoPend;
  logic        sdaLow;

  assign qtick = (qCnt == QW'(QDIV - 1));
  assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) qCnt <= '0;
    else qCnt <= qtick ? '0 : qCnt + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state         <= IDLE;
      qIdx          <= '0;
      fCnt          <= '0;
      bitCnt        <= '0;
      byteCnt       <= '0;
      retry         <= '0;
      frame         <= '0;
      txSh          <= '0;
      nack          <= 1'b0;
      autoPend      <= AUTO_START;
      sdaLow        <= 1'b0;
      I2C_SCLK      <= 1'b1;
      oBUSY         <= 1'b0;
      oDONE         <= 1'b0;
      oERR          <= 1'b0;
      oERR_INDEX    <= '0;
      rom.oROM_ADDR <= '0;
    end else begin
      autoPend <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (autoPend || iSTART) begin
            state         <= FETCH;
            fCnt          <= '0;
            retry         <= '0;
            oBUSY         <= 1'b1;
            oDONE         <= 1'b0;
            oERR          <= 1'b0;
            rom.oROM_ADDR <= '0;
          end
        end
        FETCH: begin
          // table word is valid one cycle after the address moves
          if (fCnt != 2'd2) fCnt <= fCnt + 1'b1;
          if (fCnt == 2'd1)
            frame <= {DEV_ADDR, 1'b0, rom.iROM_DATA};
          if (fCnt == 2'd2 && qtick) begin
            state    <= START;
            qIdx     <= '0;
            txSh     <= frame;
            nack     <= 1'b0;
            I2C_SCLK <= 1'b1;
            sdaLow   <= 1'b0;
          end
        end
        START: begin
          if (qtick) begin
            qIdx <= qIdx + 1'b1;
            if (qIdx == 2'd0) begin
              sdaLow <= 1'b1;
            end else begin
              state    <= BIT;
              qIdx     <= '0;
              bitCnt   <= '0;
              byteCnt  <= '0;
              I2C_SCLK <= 1'b0;
              sdaLow   <= ~txSh[23];
              txSh     <= txSh << 1;
            end
          end
        end
        BIT: begin
          if (qtick) begin
            qIdx <= qIdx + 1'b1;
            if (qIdx == 2'd1) I2C_SCLK <= 1'b1;
            if (qIdx == 2'd2 && bitCnt == 4'd8 && I2C_SDAT)
              nack <= 1'b1;
            if (qIdx == 2'd3) begin
              I2C_SCLK <= 1'b0;
              if (bitCnt == 4'd8 && byteCnt == 2'd2) begin
                state  <= STOP;
                sdaLow <= 1'b1;
              end else if (bitCnt == 4'd8) begin
                bitCnt  <= '0;
                byteCnt <= byteCnt + 1'b1;
                sdaLow  <= ~txSh[23];
                txSh    <= txSh << 1;
              end else if (bitCnt == 4'd7) begin
                bitCnt <= 4'd8;
                sdaLow <= 1'b0;
              end else begin
                bitCnt <= bitCnt + 1'b1;
                sdaLow <= ~txSh[23];
                txSh   <= txSh << 1;
              end
            end
          end
        end
        STOP: begin
          if (qtick) begin
            qIdx <= qIdx + 1'b1;
            if (qIdx == 2'd0) begin
              I2C_SCLK <= 1'b1;
            end else if (qIdx == 2'd1) begin
              sdaLow <= 1'b0;
            end else begin
              state <= GAP;
              qIdx  <= '0;
            end
          end
        end
        GAP: begin
          if (qtick) begin
            qIdx <= qIdx + 1'b1;
            if (qIdx == 2'd3) begin
              if (nack && retry < MAXR) begin
                // resend the latched frame without refetching
                retry <= retry + 1'b1;
                state <= START;
                txSh  <= frame;
                nack  <= 1'b0;
              end else begin
                if (nack) begin
                  if (!oERR) oERR_INDEX <= rom.oROM_ADDR;
                  oERR <= 1'b1;
                end
                retry <= '0;
                if (rom.oROM_ADDR == LAST) begin
                  state <= DONE;
                  oBUSY <= 1'b0;
                  oDONE <= 1'b1;
                end else begin
                  state         <= FETCH;
                  fCnt          <= '0;
                  rom.oROM_ADDR <= rom.oROM_ADDR + 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_init_seq.sv
// tb_i2c_init_seq: three sequencers on ACK/NACK slave models,
// checked against a hand-written table of expected I2C frames.
module tb_i2c_init_seq;
  localparam int QA = 25;
  localparam int NENT = 11;

  typedef struct {
    logic [15:0] rom;
    logic [23:0] frame;
  } vec_t;

  vec_t vt [NENT];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
  logic startA = 1'b0, startB = 1'b0, startC = 1'b0;
  logic sclA, sclB, sclC;
  logic busyA, busyB, busyC;
  logic doneA, doneB, doneC;
  logic errA, errB, errC;
  logic [3:0] eiA, eiB, eiC;
  wire sdaA, sdaB, sdaC;
  pullup (sdaA);
  pullup (sdaB);
  pullup (sdaC);

  logic [2:0] slvLow = 3'b000;
  assign sdaA = slvLow[0] ? 1'b0 : 1'bz;
  assign sdaB = slvLow[1] ? 1'b0 : 1'bz;
  assign sdaC = slvLow[2] ? 1'b0 : 1'bz;

  i2c_init_seq_if #(.ADDR_W(4)) romA ();
  i2c_init_seq_if #(.ADDR_W(4)) romB ();
  i2c_init_seq_if #(.ADDR_W(4)) romC ();

  always @(posedge clk) begin
    romA.iROM_DATA <= vt[romA.oROM_ADDR].rom;
    romB.iROM_DATA <= vt[romB.oROM_ADDR].rom;
    romC.iROM_DATA <= vt[romC.oROM_ADDR].rom;
  end

  i2c_init_seq #(
    .CLK_FREQ(50000000), .I2C_FREQ(500000), .DEPTH(11),
    .ADDR_W(4), .DEV_ADDR(7'h1A), .MAX_RETRY(3), .AUTO_START(1'b1)
  ) dutA (
    .iCLK(clk), .iRST_N(rstA), .iSTART(startA), .rom(romA),
    .I2C_SCLK(sclA), .I2C_SDAT(sdaA), .oBUSY(busyA),
    .oDONE(doneA), .oERR(errA), .oERR_INDEX(eiA)
  );

  i2c_init_seq #(
    .CLK_FREQ(4000), .I2C_FREQ(500), .DEPTH(11),
    .ADDR_W(4), .DEV_ADDR(7'h1A), .MAX_RETRY(2), .AUTO_START(1'b1)
  ) dutB (
    .iCLK(clk), .iRST_N(rstB), .iSTART(startB), .rom(romB),
    .I2C_SCLK(sclB), .I2C_SDAT(sdaB), .oBUSY(busyB),
    .oDONE(doneB), .oERR(errB), .oERR_INDEX(eiB)
  );

  i2c_init_seq #(
    .CLK_FREQ(4000), .I2C_FREQ(500), .DEPTH(1),
    .ADDR_W(4), .DEV_ADDR(7'h1A), .MAX_RETRY(0), .AUTO_START(1'b0)
  ) dutC (
    .iCLK(clk), .iRST_N(rstC), .iSTART(startC), .rom(romC),
    .I2C_SCLK(sclC), .I2C_SDAT(sdaC), .oBUSY(busyC),
    .oDONE(doneC), .oERR(errC), .oERR_INDEX(eiC)
  );

  logic [2:0] sclV, sdaV, doneV;
  assign sclV  = {sclC, sclB, sclA};
  assign sdaV  = {sdaC, sdaB, sdaA};
  assign doneV = {doneC, doneB, doneA};

  int checks = 0;
  int errors = 0;

  int nackAlways [3];
  int nackOnce [3];
  int runBase [3];

  logic [2:0]  pScl = 3'b111, pSda = 3'b111;
  logic [7:0]  sh [3];
  logic [7:0]  by [3][3];
  logic [23:0] frames [3][64];
  int nFr [3] = '{0, 0, 0};
  int bitN [3] = '{0, 0, 0};
  int byteN [3] = '{0, 0, 0};
  int runLen [3] = '{0, 0, 0};
  int hi2Q = 0;
  int badLo = 0;

  function automatic int countEntry(int g, int e, int base);
    int n = 0;
    for (int k = base; k < nFr[g]; k++)
      if (int'(frames[g][k][15:8]) == e + 1) n++;
    return n;
  endfunction

  function automatic bit wantNack(int g, int bn);
    int e;
    if (bn == 0) return sh[g] != 8'h34;
    if (bn == 1) return 1'b0;
    e = int'(by[g][1]) - 1;
    if (e == nackAlways[g]) return 1'b1;
    return e == nackOnce[g] && countEntry(g, e, runBase[g]) == 0;
  endfunction

  // slave model and bus monitor for all three channels
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (pScl[g] && sclV[g] && pSda[g] && !sdaV[g]) begin
        bitN[g] = 0;
        byteN[g] = 0;
      end else if (pScl[g] && sclV[g] && !pSda[g] && sdaV[g]) begin
        if (byteN[g] == 3 && nFr[g] < 64) begin
          frames[g][nFr[g]] = {by[g][0], by[g][1], by[g][2]};
          nFr[g]++;
        end
        bitN[g] = 0;
        byteN[g] = 0;
      end
      if (sclV[g] != pScl[g]) begin
        if (g == 0 && sclV[g] && runLen[g] != QA && runLen[g] != 2 * QA)
          badLo++;
        if (g == 0 && !sclV[g] && runLen[g] == 2 * QA)
          hi2Q++;
        runLen[g] = 1;
      end else begin
        runLen[g]++;
      end
      if (!pScl[g] && sclV[g]) begin
        if (bitN[g] < 8) begin
          sh[g] = {sh[g][6:0], sdaV[g]};
          bitN[g]++;
        end else begin
          if (byteN[g] < 3) by[g][byteN[g]] = sh[g];
          byteN[g]++;
          bitN[g] = 0;
        end
      end
      if (pScl[g] && !sclV[g])
        slvLow[g] = (bitN[g] == 8) && !wantNack(g, byteN[g]);
      pScl[g] = sclV[g];
      pSda[g] = sdaV[g];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic waitDone(input int g, input int bound, output int cyc);
    cyc = 0;
    while (!doneV[g] && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!doneV[g]) begin
      errors++;
      $display("FAIL done_timeout_ch%0d actual=0 required=1", g);
    end
  endtask

  task automatic chkRun(string nm, int g, int base, int repE, int reps);
    int k = base;
    for (int i = 0; i < NENT; i++) begin
      int n;
      n = (i == repE) ? reps : 1;
      for (int r = 0; r < n; r++) begin
        chk($sformatf("%s_frame%0d", nm, k - base), frames[g][k], vt[i].frame);
        k++;
      end
    end
    chk({nm, "_count"}, nFr[g] - base, k - base);
  endtask

  task automatic pulseB();
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
  endtask

  task automatic testA();
    int cyc;
    #2;
    chk("A_rst_scl", sclA, 1);
    chk("A_rst_sda", sdaA, 1);
    chk("A_rst_busy", busyA, 0);
    chk("A_rst_done", doneA, 0);
    chk("A_rst_err", errA, 0);
    chk("A_rst_errIdx", eiA, 0);
    chk("A_rst_addr", romA.oROM_ADDR, 0);
    @(negedge clk);
    rstA = 1'b1;
    waitDone(0, 40000, cyc);
    checks++;
    if (cyc < 11 * 117 * QA || cyc > 11 * 117 * QA + 11 * 30) begin
      errors++;
      $display("FAIL A_run_cycles actual=%0d required=%0d..%0d",
               cyc, 11 * 117 * QA, 11 * 117 * QA + 11 * 30);
    end
    chk("A_err", errA, 0);
    chk("A_busy_end", busyA, 0);
    chk("A_entry3", frames[0][3], 24'h34047B);
    chkRun("A", 0, 0, -1, 0);
    chk("A_scl_high_2q", hi2Q, 27 * NENT);
    chk("A_scl_low_bad", badLo, 0);
  endtask

  task automatic testB();
    int cyc;
    int k;
    nackOnce[1] = 2;
    nackAlways[1] = -1;
    runBase[1] = 0;
    @(negedge clk);
    rstB = 1'b1;
    repeat (1000) @(negedge clk);
    chk("B_busy_mid", busyB, 1);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    chk("B_midstart_busy", busyB, 1);
    chk("B_midstart_done", doneB, 0);
    waitDone(1, 8000, cyc);
    chk("B1_err", errB, 0);
    chk("B1_entry2_sends", countEntry(1, 2, 0), 2);
    chkRun("B1", 1, 0, 2, 2);

    runBase[1] = nFr[1];
    nackOnce[1] = -1;
    nackAlways[1] = 5;
    pulseB();
    chk("B2_start_done", doneB, 0);
    chk("B2_start_busy", busyB, 1);
    waitDone(1, 8000, cyc);
    chk("B2_err", errB, 1);
    chk("B2_errIdx", eiB, 5);
    chk("B2_entry5_sends", countEntry(1, 5, runBase[1]), 3);
    chkRun("B2", 1, runBase[1], 5, 3);

    runBase[1] = nFr[1];
    nackAlways[1] = -1;
    pulseB();
    chk("B3_start_done", doneB, 0);
    chk("B3_start_err", errB, 0);
    waitDone(1, 8000, cyc);
    chk("B3_err", errB, 0);
    chkRun("B3", 1, runBase[1], -1, 0);

    pulseB();
    k = 0;
    while (sclB && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("B4_first_bit_scl", sclB, 0);
    chk("B4_first_bit_sda", sdaB, 0);
    rstB = 1'b0;
    #1;
    chk("B4_rst_scl", sclB, 1);
    chk("B4_rst_sda", sdaB, 1);
    chk("B4_rst_busy", busyB, 0);
    chk("B4_rst_addr", romB.oROM_ADDR, 0);
    runBase[1] = nFr[1];
    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    chk("B4_restart_busy", busyB, 1);
    chk("B4_restart_addr", romB.oROM_ADDR, 0);
    waitDone(1, 8000, cyc);
    chkRun("B4", 1, runBase[1], -1, 0);
  endtask

  task automatic testC();
    int cyc;
    nackAlways[2] = 0;
    nackOnce[2] = -1;
    runBase[2] = 0;
    @(negedge clk);
    rstC = 1'b1;
    repeat (20) @(negedge clk);
    chk("C_no_autostart", busyC, 0);
    startC = 1'b1;
    @(negedge clk);
    startC = 1'b0;
    chk("C_start_busy", busyC, 1);
    waitDone(2, 2000, cyc);
    chk("C_attempts", nFr[2], 1);
    chk("C_frame", frames[2][0], vt[0].frame);
    chk("C_err", errC, 1);
    chk("C_errIdx", eiC, 0);
    chk("C_done", doneC, 1);
    chk("C_busy", busyC, 0);
  endtask

  initial begin
    vt[0]  = '{16'h0130, 24'h340130};
    vt[1]  = '{16'h0237, 24'h340237};
    vt[2]  = '{16'h033E, 24'h34033E};
    vt[3]  = '{16'h047B, 24'h34047B};
    vt[4]  = '{16'h054C, 24'h34054C};
    vt[5]  = '{16'h0653, 24'h340653};
    vt[6]  = '{16'h075A, 24'h34075A};
    vt[7]  = '{16'h0861, 24'h340861};
    vt[8]  = '{16'h0968, 24'h340968};
    vt[9]  = '{16'h0A6F, 24'h340A6F};
    vt[10] = '{16'h0B76, 24'h340B76};
    nackAlways[0] = -1;
    nackOnce[0] = -1;
    runBase[0] = 0;
    nackAlways[1] = -1;
    nackOnce[1] = -1;
    runBase[1] = 0;
    nackAlways[2] = -1;
    nackOnce[2] = -1;
    runBase[2] = 0;
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;
    fork
      testA();
      testB();
      testC();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
